dmem_dma_arbiter: RTL and testbench

- Owns the data-memory bus in the MIPS SoC and shares it between the CPU load/store path and two DMA masters (CP2 encryption engine plus one spare slot).
- Converts DMA HOLD requests into a single HOLD to the CPU control unit, waits for the CPU's HOLD_ACK, then grants one master at a time.
- Bounds each DMA burst and guarantees the CPU a minimum window between grants.
- Drives the dmem_we/dmem_addr/dmem_out bus that the top level currently muxes by hand.

---
 rtl/dmem_dma_arbiter_if.sv | 43 ++++
 rtl/dmem_dma_arbiter.sv | 113 +++++++++++
 tb/tb_dmem_dma_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dmem_dma_arbiter_if.sv
// Data-memory bus bundle between the CPU path, two DMA masters and the arbiter.
// The arbiter uses the slave modport; the master modport drives the requesters.
interface dmem_dma_arbiter_if #(
  parameter int DW = 32
);
  logic          cpu_we;
  logic [DW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wd;
  logic          cpu_hold;
  logic          cpu_hold_ack;

  logic          dma0_hold;
  logic          dma0_hold_ack;
  logic          dma0_we;
  logic [DW-1:0] dma0_addr;
  logic [DW-1:0] dma0_wd;

  logic          dma1_hold;
  logic          dma1_hold_ack;
  logic          dma1_we;
  logic [DW-1:0] dma1_addr;
  logic [DW-1:0] dma1_wd;

  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_out;

  modport slave (
    input  cpu_we, cpu_addr, cpu_wd, cpu_hold_ack,
    input  dma0_hold, dma0_we, dma0_addr, dma0_wd,
    input  dma1_hold, dma1_we, dma1_addr, dma1_wd,
    output cpu_hold, dma0_hold_ack, dma1_hold_ack,
    output dmem_we, dmem_addr, dmem_out
  );

  modport master (
    output cpu_we, cpu_addr, cpu_wd, cpu_hold_ack,
    output dma0_hold, dma0_we, dma0_addr, dma0_wd,
    output dma1_hold, dma1_we, dma1_addr, dma1_wd,
    input  cpu_hold, dma0_hold_ack, dma1_hold_ack,
    input  dmem_we, dmem_addr, dmem_out
  );
endinterface

// File: rtl/dmem_dma_arbiter.sv
// Shares the data-memory bus between the CPU and two DMA masters via a CPU HOLD
// handshake, with bounded bursts and a guaranteed CPU window between tenures.
//
// state | meaning
// IDLE  | CPU owns bus, arbitrating pending DMA holds
// REQ   | cpu_hold raised, waiting for cpu_hold_ack
// GRANT | selected master owns the bus, burst counter running
// GAP   | CPU window after a tenure or abort, CPU_SLOT cycles
module dmem_dma_arbiter #(
  parameter int BURST_MAX = 16,
  parameter int CPU_SLOT  = 2,
  parameter int DW        = 32
) (
  input  logic clk,
  input  logic rst,
  dmem_dma_arbiter_if.slave bus,
  output logic grant_id,
  output logic bus_err
);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int GW = $clog2(CPU_SLOT + 1);

  typedef enum logic [1:0] {IDLE, REQ, GRANT, GAP} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] burst_cnt, burst_cnt_nxt;
  logic [GW-1:0] gap_cnt, gap_cnt_nxt;
  logic          rr_ptr, rr_ptr_nxt;
  logic          grant_id_nxt, bus_err_nxt;
  logic          cpu_hold_nxt, ack0_nxt, ack1_nxt;
  logic          sel_hold;

  assign sel_hold = grant_id ? bus.dma1_hold : bus.dma0_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      burst_cnt         <= '0;
      gap_cnt           <= '0;
      rr_ptr            <= 1'b0;
      grant_id          <= 1'b0;
      bus_err           <= 1'b0;
      bus.cpu_hold      <= 1'b0;
      bus.dma0_hold_ack <= 1'b0;
      bus.dma1_hold_ack <= 1'b0;
    end else begin
      state             <= state_nxt;
      burst_cnt         <= burst_cnt_nxt;
      gap_cnt           <= gap_cnt_nxt;
      rr_ptr            <= rr_ptr_nxt;
      grant_id          <= grant_id_nxt;
      bus_err           <= bus_err_nxt;
      bus.cpu_hold      <= cpu_hold_nxt;
      bus.dma0_hold_ack <= ack0_nxt;
      bus.dma1_hold_ack <= ack1_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    gap_cnt_nxt   = gap_cnt;
    rr_ptr_nxt    = rr_ptr;
    grant_id_nxt  = grant_id;
    bus_err_nxt   = bus_err;
    case (state)
      IDLE: begin
        if (bus.dma0_hold || bus.dma1_hold) begin
          grant_id_nxt = (bus.dma0_hold && bus.dma1_hold) ? rr_ptr : bus.dma1_hold;
          state_nxt    = REQ;
        end
      end
      REQ: begin
        // A withdrawn request wins over a simultaneous ack: never grant an idle master.
        if (!sel_hold) begin
          state_nxt   = GAP;
          gap_cnt_nxt = '0;
        end else if (bus.cpu_hold_ack) begin
          state_nxt     = GRANT;
          burst_cnt_nxt = '0;
        end
      end
      GRANT: begin
        burst_cnt_nxt = burst_cnt + 1'b1;
        if (!bus.cpu_hold_ack) bus_err_nxt = 1'b1;
        if (!sel_hold || burst_cnt == BW'(BURST_MAX - 1) || !bus.cpu_hold_ack) begin
          state_nxt   = GAP;
          gap_cnt_nxt = '0;
          rr_ptr_nxt  = ~grant_id;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(CPU_SLOT - 1)) state_nxt = IDLE;
        else gap_cnt_nxt = gap_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_hold_nxt = (state_nxt == REQ) || (state_nxt == GRANT);
    ack0_nxt     = (state_nxt == GRANT) && !grant_id_nxt;
    ack1_nxt     = (state_nxt == GRANT) &&  grant_id_nxt;
    bus.dmem_we   = bus.cpu_we;
    bus.dmem_addr = bus.cpu_addr;
    bus.dmem_out  = bus.cpu_wd;
    if (state == GRANT) begin
      bus.dmem_we   = grant_id ? bus.dma1_we   : bus.dma0_we;
      bus.dmem_addr = grant_id ? bus.dma1_addr : bus.dma0_addr;
      bus.dmem_out  = grant_id ? bus.dma1_wd   : bus.dma0_wd;
    end
  end
endmodule

// File: tb/tb_dmem_dma_arbiter.sv
// Bench for dmem_dma_arbiter: directed scenarios then random traffic, every cycle
// compared against a tenure/window model of the arbitration rules.
module tb_dmem_dma_arbiter;
  localparam int DW   = 32;
  localparam int BMAX = 4;
  localparam int SLOT = 2;

  logic clk = 1'b0;
  logic rst;
  logic grant_id, bus_err;

  dmem_dma_arbiter_if #(.DW(DW)) bus ();

  dmem_dma_arbiter #(.BURST_MAX(BMAX), .CPU_SLOT(SLOT), .DW(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .grant_id(grant_id), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Model: who is waiting/owning, how long the tenure has run, how much CPU window is left.
  typedef enum {M_FREE, M_ASK, M_OWN, M_CPU} phase_t;
  phase_t ph;
  int     tenure, win;
  logic   sel, rr, err;
  logic   h0r, h1r;

  task automatic model_reset();
    ph = M_FREE; tenure = 0; win = 0; sel = 1'b0; rr = 1'b0; err = 1'b0;
  endtask

  task automatic model_step();
    logic h0, h1, hs, ack;
    h0 = bus.dma0_hold; h1 = bus.dma1_hold; ack = bus.cpu_hold_ack;
    hs = sel ? h1 : h0;
    if (rst) begin
      model_reset();
    end else begin
      case (ph)
        M_FREE: if (h0 || h1) begin
          sel = (h0 && h1) ? rr : h1;
          ph  = M_ASK;
        end
        M_ASK: begin
          if (!hs) begin ph = M_CPU; win = SLOT; end
          else if (ack) begin ph = M_OWN; tenure = 1; end
        end
        M_OWN: begin
          if (!ack) err = 1'b1;
          if (!hs || tenure == BMAX || !ack) begin
            ph = M_CPU; win = SLOT; rr = ~sel;
          end else tenure++;
        end
        M_CPU: begin
          win--;
          if (win == 0) ph = M_FREE;
        end
      endcase
    end
  endtask

  task automatic compare();
    logic own;
    own = (ph == M_OWN);
    chk("cpu_hold", bus.cpu_hold, (ph == M_ASK) || own);
    chk("ack0", bus.dma0_hold_ack, own && !sel);
    chk("ack1", bus.dma1_hold_ack, own && sel);
    chk("grant_id", grant_id, sel);
    chk("bus_err", bus_err, err);
    chk("dmem_we", bus.dmem_we, own ? (sel ? bus.dma1_we : bus.dma0_we) : bus.cpu_we);
    chk("dmem_addr", bus.dmem_addr, own ? (sel ? bus.dma1_addr : bus.dma0_addr) : bus.cpu_addr);
    chk("dmem_out", bus.dmem_out, own ? (sel ? bus.dma1_wd : bus.dma0_wd) : bus.cpu_wd);
  endtask

  task automatic drive(input int cyc);
    logic follow;
    follow = bus.cpu_hold;
    bus.cpu_we    = 1'($urandom_range(1));
    bus.cpu_addr  = $urandom;
    bus.cpu_wd    = $urandom;
    bus.dma0_we   = 1'($urandom_range(1));
    bus.dma0_addr = $urandom;
    bus.dma0_wd   = $urandom;
    bus.dma1_we   = 1'($urandom_range(1));
    bus.dma1_addr = $urandom;
    bus.dma1_wd   = $urandom;
    rst = 1'b0;
    bus.cpu_hold_ack = follow;
    if (cyc < 20) begin
      rst = (cyc < 2);
      bus.dma0_hold = (cyc >= 3 && cyc < 8);
      bus.dma1_hold = 1'b0;
    end else if (cyc < 70) begin
      bus.dma0_hold = 1'b1;
      bus.dma1_hold = 1'b1;
    end else if (cyc < 80) begin
      bus.dma0_hold = 1'b0;
      bus.dma1_hold = 1'b0;
    end else if (cyc < 120) begin
      bus.dma0_hold = 1'b0;
      bus.dma1_hold = 1'b1;
    end else if (cyc < 140) begin
      bus.dma0_hold = (cyc == 130);
      bus.dma1_hold = 1'b0;
      if (cyc >= 130) bus.cpu_hold_ack = 1'b0;
    end else if (cyc < 190) begin
      bus.dma0_hold = (cyc < 186);
      bus.dma1_hold = 1'b0;
      if (cyc == 150) bus.cpu_hold_ack = 1'b0;
      rst = (cyc == 175);
    end else begin
      if ($urandom_range(7) == 0) h0r = ~h0r;
      if ($urandom_range(7) == 0) h1r = ~h1r;
      bus.dma0_hold = h0r;
      bus.dma1_hold = h1r;
      if ($urandom_range(49) == 0) bus.cpu_hold_ack = 1'b0;
      rst = ($urandom_range(299) == 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wd = '0; bus.cpu_hold_ack = 1'b0;
    bus.dma0_hold = 1'b0; bus.dma0_we = 1'b0; bus.dma0_addr = '0; bus.dma0_wd = '0;
    bus.dma1_hold = 1'b0; bus.dma1_we = 1'b0; bus.dma1_addr = '0; bus.dma1_wd = '0;
    h0r = 1'b0; h1r = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      compare();
      drive(cyc);
      model_step();
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
